// File: rtl/baseball_pkg.sv
// baseball_pkg: shared state, result and hit-pulse definitions for the game controller
//   exports: state codes, result_t, HIT_* bit positions within hit_pulse
package baseball_pkg;
   localparam logic [1:0] READY = 2'd0, PITCH = 2'd1, WAIT_RESULT = 2'd2, OVER = 2'd3;
   typedef enum logic [2:0] {R_NONE, R_SINGLE, R_DOUBLE, R_TRIPLE, R_HOMERUN, R_OUT} result_t;
   localparam int HIT_HOMERUN = 0, HIT_TRIPLE = 1, HIT_DOUBLE = 2, HIT_SINGLE = 3;
endpackage

// File: rtl/runner_advance.sv
// runner_advance: combinational runner movement and runs scored for one at-bat result
//   bases      in   runners on [0] first, [1] second, [2] third
//   result     in   at-bat result; R_NONE/R_OUT leave the bases untouched
//   next_bases out  runners after the play
//   runs       out  runs crossing home on the play
module runner_advance
   import baseball_pkg::*;
(
   input  logic [2:0] bases,
   input  result_t    result,
   output logic [2:0] next_bases,
   output logic [2:0] runs
);
   logic [2:0] pc;
   always_comb begin
      pc = 3'(bases[0]) + 3'(bases[1]) + 3'(bases[2]);
      next_bases = result == R_SINGLE  ? {bases[1:0], 1'b1} :
                   result == R_DOUBLE  ? {bases[0], 2'b10}  :
                   result == R_TRIPLE  ? 3'b100             :
                   result == R_HOMERUN ? 3'b000             : bases;
      runs = result == R_SINGLE  ? 3'(bases[2])                :
             result == R_DOUBLE  ? 3'(bases[2]) + 3'(bases[1]) :
             result == R_TRIPLE  ? pc                          :
             result == R_HOMERUN ? pc + 3'd1                   : 3'd0;
   end
endmodule

// File: rtl/game_controller.sv
// game_controller: sequences a baseball game around the batting unit
//   clk, reset (async, active-high), new_game (sync clear)
//   swing, hit_pulse {single,double,triple,homerun}, out_pulse  -> button and batting-unit inputs
//   bat_start, bases, outs, half, inning, score_top, score_bottom, game_over -> registered outputs
module game_controller
   import baseball_pkg::*;
#(
   parameter int INNINGS     = 9,
   parameter int SCORE_W     = 7,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               new_game,
   input  logic               swing,
   input  logic [3:0]         hit_pulse,
   input  logic               out_pulse,
   output logic               bat_start,
   output logic [2:0]         bases,
   output logic [1:0]         outs,
   output logic               half,
   output logic [3:0]         inning,
   output logic [SCORE_W-1:0] score_top,
   output logic [SCORE_W-1:0] score_bottom,
   output logic               game_over
);
   localparam int CW = $clog2(TIMEOUT_CYC);
   localparam int SW = SCORE_W + 3;
   logic [1:0]         state_q, state_d;
   logic               swing_q, bat_start_q, game_over_q;
   logic [2:0]         bases_q, bases_d, nb, runs;
   logic [1:0]         outs_q, outs_d;
   logic               half_q, half_d;
   logic [3:0]         inning_q, inning_d;
   logic [SCORE_W-1:0] top_q, top_d, bot_q, bot_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [SW-1:0]      top_sum, bot_sum;
   logic               is_hit, last, third, walkoff, over_now;
   result_t            res;

   runner_advance u_adv (.bases(bases_q), .result(res), .next_bases(nb), .runs(runs));

   always_comb begin
      res = state_q != WAIT_RESULT        ? R_NONE    :
            hit_pulse[HIT_HOMERUN]        ? R_HOMERUN :
            hit_pulse[HIT_TRIPLE]         ? R_TRIPLE  :
            hit_pulse[HIT_DOUBLE]         ? R_DOUBLE  :
            hit_pulse[HIT_SINGLE]         ? R_SINGLE  :
            out_pulse || cnt_q == CW'(TIMEOUT_CYC - 1) ? R_OUT : R_NONE;
      is_hit  = res != R_NONE && res != R_OUT;
      top_sum = SW'(top_q) + SW'(runs);
      bot_sum = SW'(bot_q) + SW'(runs);
      // any carry above SCORE_W means the counter is pinned at all-ones
      top_d = is_hit && !half_q ? (|top_sum[SW-1:SCORE_W] ? '1 : top_sum[SCORE_W-1:0]) : top_q;
      bot_d = is_hit && half_q  ? (|bot_sum[SW-1:SCORE_W] ? '1 : bot_sum[SCORE_W-1:0]) : bot_q;
      last     = inning_q == 4'(INNINGS);
      third    = res == R_OUT && outs_q == 2'd2;
      walkoff  = is_hit && half_q && last && bot_d > top_q;
      // final top half ends the game only if home already leads; final bottom half always ends it
      over_now = walkoff || (third && last && (half_q || bot_q > top_q));
      state_d = state_q == READY ? (swing && !swing_q ? PITCH : READY) :
                state_q == PITCH ? (swing ? PITCH : WAIT_RESULT) :
                state_q == WAIT_RESULT ? (res == R_NONE ? WAIT_RESULT : over_now ? OVER : READY) : OVER;
      bases_d  = third ? 3'b000 : is_hit ? nb : bases_q;
      outs_d   = res == R_OUT ? (third ? 2'd0 : outs_q + 2'd1) : outs_q;
      half_d   = third && !over_now ? ~half_q : half_q;
      inning_d = third && !over_now && half_q ? inning_q + 4'd1 : inning_q;
      cnt_d    = state_q == WAIT_RESULT && res == R_NONE ? cnt_q + 1'b1 : '0;
   end

   // swing_q clears to 1 so a button already held at reset/new_game is not a rising edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= READY; swing_q <= 1'b1; bat_start_q <= 1'b0; game_over_q <= 1'b0;
         bases_q <= '0; outs_q <= '0; half_q <= 1'b0; inning_q <= 4'd1;
         top_q <= '0; bot_q <= '0; cnt_q <= '0;
      end else if (new_game) begin
         state_q <= READY; swing_q <= 1'b1; bat_start_q <= 1'b0; game_over_q <= 1'b0;
         bases_q <= '0; outs_q <= '0; half_q <= 1'b0; inning_q <= 4'd1;
         top_q <= '0; bot_q <= '0; cnt_q <= '0;
      end else begin
         state_q <= state_d; swing_q <= swing;
         bat_start_q <= state_d == PITCH; game_over_q <= state_d == OVER;
         bases_q <= bases_d; outs_q <= outs_d; half_q <= half_d; inning_q <= inning_d;
         top_q <= top_d; bot_q <= bot_d; cnt_q <= cnt_d;
      end
   end

   assign bat_start    = bat_start_q;
   assign game_over    = game_over_q;
   assign bases        = bases_q;
   assign outs         = outs_q;
   assign half         = half_q;
   assign inning       = inning_q;
   assign score_top    = top_q;
   assign score_bottom = bot_q;
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: two parameterisations driven in lockstep and checked against a rules-level game model
module tb_game_controller;
   logic clk = 1'b0, reset = 1'b1, new_game = 1'b0, swing = 1'b0, out_pulse = 1'b0;
   logic [3:0] hit_pulse = 4'b0;
   logic bs_a, go_a, half_a, bs_b, go_b, half_b;
   logic [2:0] bases_a, bases_b;
   logic [1:0] outs_a, outs_b;
   logic [3:0] inn_a, inn_b;
   logic [6:0] st_a, sb_a;
   logic [2:0] st_b, sb_b;
   int checks = 0, failures = 0;

   typedef struct {
      bit [2:0] on;
      int outs, half, inning, st, sb;
      bit over;
   } model_t;
   model_t m[2];
   int INN[2] = '{9, 2};
   int SWD[2] = '{7, 3};
   int TMO[2] = '{16, 4};

   always #5 clk = ~clk;

   game_controller #(.INNINGS(9), .SCORE_W(7), .TIMEOUT_CYC(16)) dut_a (
      .clk(clk), .reset(reset), .new_game(new_game), .swing(swing), .hit_pulse(hit_pulse),
      .out_pulse(out_pulse), .bat_start(bs_a), .bases(bases_a), .outs(outs_a), .half(half_a),
      .inning(inn_a), .score_top(st_a), .score_bottom(sb_a), .game_over(go_a));
   game_controller #(.INNINGS(2), .SCORE_W(3), .TIMEOUT_CYC(4)) dut_b (
      .clk(clk), .reset(reset), .new_game(new_game), .swing(swing), .hit_pulse(hit_pulse),
      .out_pulse(out_pulse), .bat_start(bs_b), .bases(bases_b), .outs(outs_b), .half(half_b),
      .inning(inn_b), .score_top(st_b), .score_bottom(sb_b), .game_over(go_b));

   function automatic model_t fresh();
      model_t r;
      r.on = 0; r.outs = 0; r.half = 0; r.inning = 1; r.st = 0; r.sb = 0; r.over = 0;
      return r;
   endfunction

   // res: 0 none, 1..4 bases gained by the batter, 5 out
   function automatic model_t apply(model_t s, int k, int res);
      model_t r = s;
      int runs = 0, cap = (1 << SWD[k]) - 1;
      bit [2:0] nb = 0;
      if (r.over || res == 0) return r;
      if (res == 5) begin
         if (r.outs < 2) r.outs++;
         else begin
            r.outs = 0; r.on = 0;
            if (r.half == 0) begin
               if (r.inning == INN[k] && r.sb > r.st) r.over = 1; else r.half = 1;
            end else if (r.inning == INN[k]) r.over = 1;
            else begin r.half = 0; r.inning++; end
         end
      end else begin
         for (int b = 0; b < 3; b++)
            if (r.on[b]) begin
               if (b + res >= 3) runs++; else nb[b + res] = 1'b1;
            end
         if (res == 4) runs++; else nb[res - 1] = 1'b1;
         r.on = nb;
         if (r.half == 0) r.st = r.st + runs > cap ? cap : r.st + runs;
         else r.sb = r.sb + runs > cap ? cap : r.sb + runs;
         if (r.half == 1 && r.inning == INN[k] && r.sb > r.st) r.over = 1;
      end
      return r;
   endfunction

   function automatic int decode(logic [3:0] hp, logic op);
      return hp[0] ? 4 : hp[1] ? 3 : hp[2] ? 2 : hp[3] ? 1 : op ? 5 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input int exp);
      checks++;
      if (got !== 32'(exp)) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic compare(input string tag, input bit pitch);
      for (int k = 0; k < 2; k++) begin
         string p = $sformatf("%s.%s", tag, k == 0 ? "a" : "b");
         chk({p, ".bat_start"}, k == 0 ? 32'(bs_a) : 32'(bs_b), int'(pitch && !m[k].over));
         chk({p, ".bases"}, k == 0 ? 32'(bases_a) : 32'(bases_b), int'(m[k].on));
         chk({p, ".outs"}, k == 0 ? 32'(outs_a) : 32'(outs_b), m[k].outs);
         chk({p, ".half"}, k == 0 ? 32'(half_a) : 32'(half_b), m[k].half);
         chk({p, ".inning"}, k == 0 ? 32'(inn_a) : 32'(inn_b), m[k].inning);
         chk({p, ".score_top"}, k == 0 ? 32'(st_a) : 32'(st_b), m[k].st);
         chk({p, ".score_bottom"}, k == 0 ? 32'(sb_a) : 32'(sb_b), m[k].sb);
         chk({p, ".game_over"}, k == 0 ? 32'(go_a) : 32'(go_b), int'(m[k].over));
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_new_game();
      new_game = 1'b1; cyc(); new_game = 1'b0;
      m[0] = fresh(); m[1] = fresh();
      compare("new_game", 0);
   endtask

   // h cycles of swing high, pulse sampled d edges after entering WAIT_RESULT
   task automatic atbat(input int h, input int d, input logic [3:0] hp, input logic op, input bit hold);
      int res = decode(hp, op);
      swing = 1'b0; cyc(); compare("ready", 0);
      swing = 1'b1;
      for (int i = 0; i < h; i++) begin cyc(); compare("pitch", 1); end
      swing = 1'b0; cyc(); compare("wait", 0);
      for (int c = 1; c < d; c++) begin
         cyc();
         for (int j = 0; j < 2; j++) if (c == TMO[j]) m[j] = apply(m[j], j, 5);
         compare("tmo", 0);
      end
      hit_pulse = hp; out_pulse = op;
      if (hold) swing = 1'b1;
      cyc();
      hit_pulse = 4'b0; out_pulse = 1'b0;
      for (int j = 0; j < 2; j++)
         if (d <= TMO[j]) m[j] = apply(m[j], j, res == 0 && d == TMO[j] ? 5 : res);
      compare("result", 0);
      if (hold) begin
         repeat (2) begin cyc(); compare("held", 0); end
         swing = 1'b0;
      end
   endtask

   task automatic hit(input int n);
      atbat($urandom_range(1, 3), $urandom_range(1, 3), 4'(4'b1000 >> (n - 1)), 1'b0, 1'b0);
   endtask

   task automatic outs_n(input int c);
      repeat (c) atbat($urandom_range(1, 3), $urandom_range(1, 3), 4'b0, 1'b1, 1'b0);
   endtask

   initial begin
      m[0] = fresh(); m[1] = fresh();
      repeat (2) cyc();
      compare("reset", 0);
      reset = 1'b0;
      cyc(); compare("reset_rel", 0);

      atbat(3, 2, 4'b1000, 1'b0, 1'b0);
      chk("s1.bases", 32'(bases_a), 1);
      chk("s1.score", 32'(st_a), 0);
      hit(1); hit(1);
      atbat(2, 1, 4'b0001, 1'b1, 1'b0);
      chk("grand_slam.score_top", 32'(st_a), 4);
      chk("grand_slam.bases", 32'(bases_a), 0);
      chk("grand_slam.outs", 32'(outs_a), 0);

      do_new_game();
      outs_n(12); outs_n(2); hit(1); hit(2);
      chk("s3.bases", 32'(bases_a), 6);
      outs_n(1);
      chk("s3.half", 32'(half_a), 1);
      chk("s3.inning", 32'(inn_a), 3);
      outs_n(3);
      chk("s3.inning_next", 32'(inn_a), 4);

      do_new_game();
      hit(4); outs_n(3); hit(4); hit(4); hit(4); outs_n(3); outs_n(3);
      chk("home_leads.game_over", 32'(go_b), 1);
      atbat(2, 1, 4'b0001, 1'b1, 1'b0);
      chk("over_ignored.score_bottom", 32'(sb_b), 3);
      do_new_game();

      hit(4); hit(4); outs_n(3); hit(4); hit(4); outs_n(3); outs_n(3); hit(3);
      chk("walkoff.pre_bases", 32'(bases_b), 4);
      hit(2);
      chk("walkoff.score_bottom", 32'(sb_b), 3);
      chk("walkoff.game_over", 32'(go_b), 1);

      do_new_game();
      atbat(1, 6, 4'b1000, 1'b0, 1'b0);
      chk("timeout.outs", 32'(outs_b), 1);
      atbat(1, 2, 4'b0100, 1'b0, 1'b1);

      do_new_game();
      repeat (6) hit(4);
      repeat (3) hit(1);
      hit(4);
      chk("saturate.score_top", 32'(st_b), 7);

      swing = 1'b0; cyc();
      swing = 1'b1; cyc(); compare("pre_reset", 1);
      #2 reset = 1'b1; #1;
      chk("async_reset.bat_start", 32'(bs_a), 0);
      swing = 1'b0; cyc(); reset = 1'b0;
      m[0] = fresh(); m[1] = fresh();
      compare("post_reset", 0);

      do_new_game();
      repeat (90) begin
         int r = $urandom_range(0, 8);
         int d = $urandom_range(1, 6);
         logic [3:0] hp = 4'b0;
         logic op = 1'b0;
         if (r < 4) hp = 4'(4'b1000 >> r);
         else if (r < 8) op = 1'b1;
         else begin hp = 4'($urandom_range(1, 15)); op = 1'($urandom_range(0, 1)); end
         if (m[0].over && m[1].over) do_new_game();
         atbat($urandom_range(1, 3), d, hp, op, d <= 4 && $urandom_range(0, 3) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
